dcache_ctrl: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache controller between the CPU pipeline's memory stage and the data memory. It serves word reads on hits in the same cycle and fetches 16-byte lines from memory on misses. Every store is forwarded to memory as a single 32-bit write. It drives the memory's address/write/data inputs and consumes the memory's 128-bit line output.

---
 rtl/dcache_ctrl.sv | 166 ++++++++++++++++
 tb/tb_dcache_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-through, no-write-allocate data cache controller
module dcache_ctrl #(
    parameter int NUM_LINES   = 16,
    parameter int MEM_LATENCY = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cpu_req,
    input  logic         cpu_we,
    input  logic [31:0]  cpu_addr,
    input  logic [31:0]  cpu_wdata,
    output logic [31:0]  cpu_rdata,
    output logic         cpu_ready,
    output logic [31:0]  mem_addr,
    output logic         mem_we,
    output logic [31:0]  mem_wdata,
    input  logic [127:0] mem_line,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
);

    localparam int IB = $clog2(NUM_LINES);
    localparam int TW = 28 - IB;
    localparam int CW = $clog2(MEM_LATENCY + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [1:0]           r_state;
    logic [CW-1:0]        r_cnt;
    logic [NUM_LINES-1:0] r_valid;
    logic [TW-1:0]        r_tag  [NUM_LINES];
    logic [127:0]         r_data [NUM_LINES];
    logic [27:0]          r_fill_addr;
    logic [31:0]          r_mem_addr;
    logic                 r_mem_we;
    logic [31:0]          r_mem_wdata;
    logic [31:0]          r_hit_count;
    logic [31:0]          r_miss_count;

    logic [IB-1:0]  w_idx;
    logic [TW-1:0]  w_tag;
    logic [1:0]     w_word;
    logic           w_hit;
    logic [127:0]   w_sel_line;
    logic [IB-1:0]  w_fidx;
    logic [TW-1:0]  w_ftag;
    logic           w_fill_done;
    logic [IB-1:0]  w_sidx;
    logic [TW-1:0]  w_stag;
    logic           w_st_hit;
    logic [127:0]   w_merged;
    logic           w_unused;

    assign w_idx      = cpu_addr[4+IB-1:4];
    assign w_tag      = cpu_addr[31:4+IB];
    assign w_word     = cpu_addr[3:2];
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_sel_line = r_data[w_idx];
    assign w_unused   = ^cpu_addr[1:0];

    // Fill uses the address latched on entry so a moving cpu_addr cannot corrupt it.
    assign w_fidx      = r_fill_addr[IB-1:0];
    assign w_ftag      = r_fill_addr[27:IB];
    assign w_fill_done = (r_state == S_FILL) && (r_cnt == CW'(MEM_LATENCY));

    assign w_sidx   = r_mem_addr[4+IB-1:4];
    assign w_stag   = r_mem_addr[31:4+IB];
    assign w_st_hit = (r_state == S_WRITE) && r_valid[w_sidx] && (r_tag[w_sidx] == w_stag);

    always_comb begin
        cpu_rdata = 32'd0;
        case (w_word)
            2'd0:    cpu_rdata = w_sel_line[127:96];
            2'd1:    cpu_rdata = w_sel_line[95:64];
            2'd2:    cpu_rdata = w_sel_line[63:32];
            default: cpu_rdata = w_sel_line[31:0];
        endcase
    end

    always_comb begin
        w_merged = r_data[w_sidx];
        case (r_mem_addr[3:2])
            2'd0:    w_merged[127:96] = r_mem_wdata;
            2'd1:    w_merged[95:64]  = r_mem_wdata;
            2'd2:    w_merged[63:32]  = r_mem_wdata;
            default: w_merged[31:0]   = r_mem_wdata;
        endcase
    end

    always_comb begin
        cpu_ready = 1'b0;
        if (!rst) begin
            cpu_ready = (r_state == S_WRITE) ||
                        ((r_state == S_IDLE) && cpu_req && !cpu_we && w_hit);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_valid      <= '0;
            r_fill_addr  <= '0;
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cpu_req) begin
                        if (cpu_we) begin
                            r_mem_addr  <= cpu_addr;
                            r_mem_wdata <= cpu_wdata;
                            r_mem_we    <= 1'b1;
                            r_state     <= S_WRITE;
                        end else if (w_hit) begin
                            r_hit_count <= r_hit_count + 32'd1;
                        end else begin
                            r_mem_addr   <= {cpu_addr[31:4], 4'b0};
                            r_fill_addr  <= cpu_addr[31:4];
                            r_cnt        <= '0;
                            r_miss_count <= r_miss_count + 32'd1;
                            r_state      <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (w_fill_done) begin
                        r_valid[w_fidx] <= 1'b1;
                        r_state         <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WRITE: begin
                    r_mem_we <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tag/data arrays need no reset: the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_fill_done) begin
                r_data[w_fidx] <= mem_line;
                r_tag[w_fidx]  <= w_ftag;
            end else if (w_st_hit) begin
                r_data[w_sidx] <= w_merged;
            end
        end
    end

    assign mem_addr   = r_mem_addr;
    assign mem_we     = r_mem_we;
    assign mem_wdata  = r_mem_wdata;
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - scoreboard bench for dcache_ctrl with a latency-modelled memory
module tb_dcache_ctrl;

    localparam int NL  = 16;
    localparam int LAT = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_req;
    logic         cpu_we;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic [31:0]  mem_addr;
    logic         mem_we;
    logic [31:0]  mem_wdata;
    logic [127:0] mem_line = '0;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    dcache_ctrl #(.NUM_LINES(NL), .MEM_LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_line   (mem_line),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mem_words [256];
    logic        mv [NL];
    logic [23:0] mt [NL];
    int          exp_hit = 0;
    int          exp_miss = 0;
    int          mlat = 0;
    logic [31:0] last_addr = '0;

    // Memory: line becomes valid LAT posedges after mem_addr last changed; writes land on negedge.
    always @(negedge clk) begin
        if (mem_addr !== last_addr) begin
            mlat = 1;
            last_addr = mem_addr;
        end else if (mlat < 1000) begin
            mlat++;
        end
        if (mem_we === 1'b1) mem_words[mem_addr[9:2]] = mem_wdata;
        if (mlat >= LAT)
            mem_line = {mem_words[{mem_addr[9:4], 2'd0}], mem_words[{mem_addr[9:4], 2'd1}],
                        mem_words[{mem_addr[9:4], 2'd2}], mem_words[{mem_addr[9:4], 2'd3}]};
        else
            mem_line = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        forever begin
            @(negedge clk);
            if (cpu_ready === 1'b1) break;
            n++;
            if (n > 50) begin
                check("ready_timeout", 32'(n), 32'd0);
                break;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NL; i++) mv[i] = 1'b0;
        exp_hit = 0;
        exp_miss = 0;
    endtask

    task automatic do_load(input logic [31:0] a);
        exp_t e;
        int   idx;
        int   n;
        idx = int'(a[7:4]);
        e.rdata = mem_words[a[9:2]];
        if (mv[idx] && mt[idx] == a[31:8]) begin
            e.lat = 0;
        end else begin
            e.lat = LAT + 2;
            mv[idx] = 1'b1;
            mt[idx] = a[31:8];
            exp_miss++;
        end
        exp_hit++;
        sb.push_back(e);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
        wait_ready(n);
        e = sb.pop_front();
        check("ld_latency", 32'(n), 32'(e.lat));
        check("ld_rdata", cpu_rdata, e.rdata);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        check("hit_count", hit_count, 32'(exp_hit));
        check("miss_count", miss_count, 32'(exp_miss));
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   n;
        e.rdata = d;
        e.lat = 1;
        sb.push_back(e);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        wait_ready(n);
        e = sb.pop_front();
        check("st_latency", 32'(n), 32'(e.lat));
        check("st_mem_we", 32'(mem_we), 32'd1);
        check("st_mem_addr", mem_addr, a);
        check("st_mem_wdata", mem_wdata, e.rdata);
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        check("st_we_drop", 32'(mem_we), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [31:0] b;
            b = 32'(i * 4) - 32'h40;
            mem_words[i] = {b[7:0], b[7:0] + 8'd1, b[7:0] + 8'd2, b[7:0] + 8'd3};
        end
        model_reset();
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(cpu_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_hits", hit_count, 32'd0);
        check("rst_misses", miss_count, 32'd0);

        do_load(32'h40);
        do_load(32'h4C);
        check("hit_mem_addr_held", mem_addr, 32'h40);
        do_store(32'h44, 32'hDEADBEEF);
        do_load(32'h44);
        do_store(32'h200, 32'hCAFEF00D);
        do_load(32'h48);
        do_load(32'h200);
        do_load(32'h40);
        do_load(32'h140);
        do_load(32'h40);
        do_load(32'h144);
        for (int k = 0; k < 6; k++) do_load(32'h80 + 32'(k * 4));

        // Reset in the middle of a fill: nothing installed, everything cleared.
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h300;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1; cpu_req = 1'b0;
        @(negedge clk);
        check("rst_hi_ready", 32'(cpu_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midfill_ready", 32'(cpu_ready), 32'd0);
        check("midfill_mem_we", 32'(mem_we), 32'd0);
        check("midfill_mem_addr", mem_addr, 32'd0);
        check("midfill_hits", hit_count, 32'd0);
        check("midfill_misses", miss_count, 32'd0);
        model_reset();
        do_load(32'h40);
        do_load(32'h300);
        do_load(32'h304);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

endmodule
